// File: rtl/dsp_fetch_pkg.sv
// Purpose: shared widths, reset vector and control-flow codes for the fetch, branch and decode blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_fetch_pkg;

    localparam int          ADDR_W_DEF       = 16;
    localparam int          INSTR_W_DEF      = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    // Source of the next fetch address in a given cycle.
    typedef enum logic [1:0] {
        FLOW_HOLD = 2'd0,   // no read this cycle, PC holds
        FLOW_SEQ  = 2'd1,   // sequential read at pc_q
        FLOW_JUMP = 2'd2    // redirected read at the branch target
    } flow_e;

endpackage

// File: rtl/dsp_fetch_skid.sv
// Purpose: two-entry output buffer (out register + skid register) between the memory response and decode.
// Latency: a push is visible on out_valid the next cycle when out is free; otherwise it waits in skid.
// Backpressure: out holds stable while not popped; the issuer keeps occupancy <= 2 so a push never finds both full.
//
// Ports: clk, rst (async active-high); push/push_data/push_pc = memory response with its address;
//        pop = decode took out this cycle; flush = drop both entries (wins over push and pop);
//        out_valid/out_data/out_pc = instruction presented to decode; skid_valid = second entry occupied.
module dsp_fetch_skid #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_data,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_data,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               skid_valid
);

    logic [INSTR_W-1:0] skid_data;
    logic [ADDR_W-1:0]  skid_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop && skid_valid) begin
            // Older skid entry advances; the new response (if any) takes its place.
            out_data   <= skid_data;
            out_pc     <= skid_pc;
            skid_valid <= push;
            if (push) begin
                skid_data <= push_data;
                skid_pc   <= push_pc;
            end
        end else if (!out_valid || pop) begin
            // Skid is empty here: it only fills while out is occupied.
            out_valid <= push;
            if (push) begin
                out_data <= push_data;
                out_pc   <= push_pc;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= push_data;
            skid_pc    <= push_pc;
        end
    end

endmodule

// File: rtl/dsp_fetch.sv
// Purpose: instruction fetch - owns the PC, reads the synchronous imem, hands instructions to decode, squashes on jumps.
// Latency: read issued in cycle N is presented to decode in cycle N+2; 1 instruction/cycle sustained.
// Backpressure: valid/ready to decode; reads stop once 2 instructions are buffered or in flight.
//
// Ports: clk, rst (async active-high); fetch_en = allow new sequential reads; jump_flag/jump_addr = taken branch;
//        imem_rd/imem_addr/imem_rdata = instruction memory (data 1 cycle after read);
//        instr_valid/instr_ready/instr/instr_pc = handshake to decode.
module dsp_fetch
    import dsp_fetch_pkg::*;
#(
    parameter int               ADDR_W       = ADDR_W_DEF,
    parameter int               INSTR_W      = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] rd_pc_q;     // address of the read issued last cycle
    logic              inflight_q;
    logic              skid_valid;
    logic              pop;
    logic              push;
    logic [1:0]        occ;
    logic [1:0]        occ_after_pop;
    flow_e             flow;

    assign pop = instr_valid & instr_ready;

    // Entries already owned by the buffer plus the read whose data lands next cycle.
    // pop implies instr_valid, so the subtraction cannot underflow.
    assign occ           = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};

    always_comb begin
        flow = FLOW_HOLD;
        if (jump_flag) begin
            flow = FLOW_JUMP;
        end else if (fetch_en && (occ_after_pop < 2'd2)) begin
            flow = FLOW_SEQ;
        end
    end

    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = pc_q;
        pc_d      = pc_q;
        case (flow)
            FLOW_JUMP: begin
                imem_rd   = ~rst;
                imem_addr = jump_addr;
                pc_d      = jump_addr + ADDR_W'(1);
            end
            FLOW_SEQ: begin
                imem_rd = ~rst;
                pc_d    = pc_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rd_pc_q    <= imem_addr;
            inflight_q <= imem_rd;
        end
    end

    // A jump this cycle kills the response of last cycle's read: it is on the wrong path.
    assign push = inflight_q & ~jump_flag;

    dsp_fetch_skid #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (imem_rdata),
        .push_pc    (rd_pc_q),
        .pop        (pop),
        .flush      (jump_flag),
        .out_valid  (instr_valid),
        .out_data   (instr),
        .out_pc     (instr_pc),
        .skid_valid (skid_valid)
    );

endmodule

// File: tb/tb_dsp_fetch.sv
// Purpose: directed self-checking bench for dsp_fetch with a queue-based scoreboard of issued-not-accepted reads.
// Latency: checks the N+2 issue-to-present latency and 1/cycle throughput.
// Backpressure: exercises decode stalls, skid fill, jumps under stall, wrap-around and async reset.
module tb_dsp_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        jump_flag = 1'b0;
    logic [15:0] jump_addr = '0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    typedef struct {
        logic [15:0] pc;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          now = 0;
    logic [15:0] exp_pc = '0;

    dsp_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at address a is a ^ 16'hA5A5.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= imem_addr ^ 16'hA5A5;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare DUT against the scoreboard, advance the model.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic run_cycle(input logic fe, input logic jf, input logic [15:0] ja, input logic rdy);
        logic ev;
        logic ep;
        logic er;
        ent_t e;
        fetch_en    = fe;
        jump_flag   = jf;
        jump_addr   = ja;
        instr_ready = rdy;
        #1;
        ev = (q.size() > 0) && (q[0].cyc + 2 <= now);
        check("instr_valid", instr_valid, ev);
        if (ev) begin
            check("instr_pc", instr_pc, q[0].pc);
            check("instr", instr, q[0].pc ^ 16'hA5A5);
        end
        ep = ev & rdy;
        er = jf | (fe && ((q.size() - (ep ? 1 : 0)) < 2));
        check("imem_rd", imem_rd, er);
        check("imem_addr", imem_addr, jf ? ja : exp_pc);
        if (jf) begin
            q.delete();
            e.pc  = ja;
            e.cyc = now;
            q.push_back(e);
            exp_pc = ja + 16'd1;
        end else begin
            if (ep) void'(q.pop_front());
            if (er) begin
                e.pc  = exp_pc;
                e.cyc = now;
                q.push_back(e);
                exp_pc = exp_pc + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        now++;
    endtask

    initial begin
        int n;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_rd", imem_rd, 0);
        check("rst_imem_addr", imem_addr, 16'h0000);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        rst = 1'b0;

        // Streaming from the reset vector, then a 5-cycle decode stall.
        repeat (5) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (5) run_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check("stall_pc", instr_pc, 16'h0003);
        check("stall_valid", instr_valid, 1);
        check("stall_no_read", imem_rd, 0);

        // Release, run until pc_q = 7, then jump to 0x40.
        n = 0;
        while (exp_pc != 16'h0007 && n < 20) begin
            run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
            n++;
        end
        check("reach_pc7", imem_addr, 16'h0007);
        run_cycle(1'b1, 1'b1, 16'h0040, 1'b1);
        repeat (4) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Fill out and skid under stall, then jump while full.
        repeat (3) run_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check("skid_full_no_read", imem_rd, 0);
        run_cycle(1'b1, 1'b1, 16'h0080, 1'b0);
        repeat (3) run_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check("flush_target_pc", instr_pc, 16'h0080);
        repeat (3) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Back-to-back jumps: the later one wins.
        run_cycle(1'b1, 1'b1, 16'h0010, 1'b1);
        run_cycle(1'b1, 1'b1, 16'h0020, 1'b1);
        repeat (5) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // PC wrap-around, sequential and after a jump to the top address.
        run_cycle(1'b1, 1'b1, 16'hFFFE, 1'b1);
        jump_flag = 1'b0;
        #1;
        check("pc_ffff", imem_addr, 16'hFFFF);
        run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check("pc_wrap", imem_addr, 16'h0000);
        repeat (3) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        run_cycle(1'b1, 1'b1, 16'hFFFF, 1'b1);
        jump_flag = 1'b0;
        #1;
        check("jump_wrap", imem_addr, 16'h0000);
        repeat (3) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Jump honoured with fetch disabled.
        repeat (4) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        run_cycle(1'b0, 1'b1, 16'h0030, 1'b1);
        repeat (4) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check("fe0_idle_rd", imem_rd, 0);
        check("fe0_drained", instr_valid, 0);

        // Asynchronous reset mid-stream; stale read data must not be delivered.
        repeat (4) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_imem_rd", imem_rd, 0);
        check("arst_imem_addr", imem_addr, 16'h0000);
        check("arst_instr_valid", instr_valid, 0);
        check("arst_instr", instr, 0);
        check("arst_instr_pc", instr_pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_pc = 16'h0000;
        repeat (6) run_cycle(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (4) run_cycle(1'b0, 1'b0, 16'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
